// File: rtl/bru_pkg.sv
// Shared widths, metadata/resolution types and the branch resolution rule
// used by the branch resolve unit and its metadata pipeline.
package bru_pkg;

  localparam int BRU_PC_W  = 9;
  localparam int BRU_DEPTH = 3;
  localparam int BRU_CNT_W = 16;

  typedef logic [BRU_PC_W-1:0] pc_t;

  typedef struct packed {
    logic valid;
    pc_t  pc;
    logic pred;
    pc_t  ptarget;
  } meta_t;

  typedef struct packed {
    logic resolved;
    logic mispredict;
    pc_t  correct_pc;
  } res_t;

  // Fall-through PC wraps modulo 2^PC_W.
  function automatic res_t bru_resolve(meta_t e, logic is_branch, logic taken, pc_t target);
    res_t r;
    r.resolved   = e.valid & is_branch;
    r.mispredict = (e.pred != taken) | (taken & (e.ptarget != target));
    r.correct_pc = taken ? target : pc_t'(e.pc + pc_t'(1));
    return r;
  endfunction

endpackage

// File: rtl/bru_if.sv
// Pipeline-side bundle of the branch resolve unit: fetch metadata, Memory-stage
// outcomes, predictor update pulses, flush/redirect and statistics.
interface bru_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
);

  logic             stall;
  logic             fetch_valid1, fetch_valid2;
  logic [PC_W-1:0]  fetch_pc1, fetch_pc2;
  logic             fetch_pred1, fetch_pred2;
  logic [PC_W-1:0]  fetch_ptarget1, fetch_ptarget2;
  logic             m_branch1, m_branch2;
  logic             m_taken1, m_taken2;
  logic [PC_W-1:0]  m_target1, m_target2;
  logic             upd_branch1, upd_branch2;
  logic             upd_taken1, upd_taken2;
  logic [PC_W-1:0]  upd_pc1, upd_pc2;
  logic [PC_W-1:0]  upd_target1, upd_target2;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output stall,
    output fetch_valid1, fetch_valid2, fetch_pc1, fetch_pc2,
    output fetch_pred1, fetch_pred2, fetch_ptarget1, fetch_ptarget2,
    output m_branch1, m_branch2, m_taken1, m_taken2, m_target1, m_target2,
    input  upd_branch1, upd_branch2, upd_taken1, upd_taken2,
    input  upd_pc1, upd_pc2, upd_target1, upd_target2,
    input  flush, redirect_pc, branch_count, mispredict_count
  );

  modport slave (
    input  stall,
    input  fetch_valid1, fetch_valid2, fetch_pc1, fetch_pc2,
    input  fetch_pred1, fetch_pred2, fetch_ptarget1, fetch_ptarget2,
    input  m_branch1, m_branch2, m_taken1, m_taken2, m_target1, m_target2,
    output upd_branch1, upd_branch2, upd_taken1, upd_taken2,
    output upd_pc1, upd_pc2, upd_target1, upd_target2,
    output flush, redirect_pc, branch_count, mispredict_count
  );

endinterface

// File: rtl/bru_meta_pipe.sv
// One slot of prediction metadata carried DEPTH stages from fetch to Memory;
// holds on stall, clears every valid on a squash edge.
module bru_meta_pipe
  import bru_pkg::*;
#(
  parameter int DEPTH = BRU_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  squash,
  input  meta_t in_entry,
  output meta_t m_entry
);

  meta_t stage_q [DEPTH];
  meta_t stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (!stall) begin
      stage_d[0] = in_entry;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      // Shift still happens on a squash so the bubbles line up with fetch restart.
      if (squash) begin
        for (int i = 0; i < DEPTH; i++) stage_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign m_entry = stage_q[DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the Memory-stage branch pair against carried predictions and drives
// predictor updates, flush/redirect and saturating branch statistics.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PC_W  = BRU_PC_W,
  parameter int DEPTH = BRU_DEPTH,
  parameter int CNT_W = BRU_CNT_W
) (
  input logic  clk,
  input logic  reset,
  bru_if.slave bus
);

  meta_t fetch1, fetch2, m1, m2;
  res_t  res1, res2;
  logic  eff1_res, eff1_mp, eff2_res, eff2_mp, squash;

  logic             upd_branch1_q, upd_branch1_d, upd_branch2_q, upd_branch2_d;
  logic             upd_taken1_q, upd_taken1_d, upd_taken2_q, upd_taken2_d;
  logic [PC_W-1:0]  upd_pc1_q, upd_pc1_d, upd_pc2_q, upd_pc2_d;
  logic [PC_W-1:0]  upd_target1_q, upd_target1_d, upd_target2_q, upd_target2_d;
  logic             flush_q, flush_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic [CNT_W:0]   bsum, msum;

  always_comb begin
    fetch1 = '{valid: bus.fetch_valid1, pc: bus.fetch_pc1, pred: bus.fetch_pred1,
               ptarget: bus.fetch_ptarget1};
    fetch2 = '{valid: bus.fetch_valid2, pc: bus.fetch_pc2, pred: bus.fetch_pred2,
               ptarget: bus.fetch_ptarget2};
  end

  bru_meta_pipe #(.DEPTH(DEPTH)) u_pipe1 (
    .clk(clk), .reset(reset), .stall(bus.stall), .squash(squash),
    .in_entry(fetch1), .m_entry(m1)
  );

  bru_meta_pipe #(.DEPTH(DEPTH)) u_pipe2 (
    .clk(clk), .reset(reset), .stall(bus.stall), .squash(squash),
    .in_entry(fetch2), .m_entry(m2)
  );

  // Slot1 is older: its mispredict makes slot2 wrong-path.
  always_comb begin
    res1     = bru_resolve(m1, bus.m_branch1, bus.m_taken1, bus.m_target1);
    res2     = bru_resolve(m2, bus.m_branch2, bus.m_taken2, bus.m_target2);
    eff1_res = res1.resolved & ~bus.stall;
    eff1_mp  = eff1_res & res1.mispredict;
    eff2_res = res2.resolved & ~bus.stall & ~eff1_mp;
    eff2_mp  = eff2_res & res2.mispredict;
    squash   = eff1_mp | eff2_mp;
  end

  always_comb begin
    upd_branch1_d = eff1_res;
    upd_taken1_d  = eff1_res & bus.m_taken1;
    upd_pc1_d     = eff1_res ? m1.pc : '0;
    upd_target1_d = eff1_res ? bus.m_target1 : '0;
    upd_branch2_d = eff2_res;
    upd_taken2_d  = eff2_res & bus.m_taken2;
    upd_pc2_d     = eff2_res ? m2.pc : '0;
    upd_target2_d = eff2_res ? bus.m_target2 : '0;

    flush_d       = squash;
    redirect_pc_d = redirect_pc_q;
    if (eff1_mp)      redirect_pc_d = res1.correct_pc;
    else if (eff2_mp) redirect_pc_d = res2.correct_pc;
  end

  // Sums carry one extra bit; a set top bit means the counter would overflow.
  always_comb begin
    bsum = {1'b0, branch_count_q} + {{CNT_W{1'b0}}, eff1_res} + {{CNT_W{1'b0}}, eff2_res};
    msum = {1'b0, mispredict_count_q} + {{CNT_W{1'b0}}, squash};
    branch_count_d     = bsum[CNT_W] ? {CNT_W{1'b1}} : bsum[CNT_W-1:0];
    mispredict_count_d = msum[CNT_W] ? {CNT_W{1'b1}} : msum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_branch1_q      <= 1'b0;
      upd_taken1_q       <= 1'b0;
      upd_pc1_q          <= '0;
      upd_target1_q      <= '0;
      upd_branch2_q      <= 1'b0;
      upd_taken2_q       <= 1'b0;
      upd_pc2_q          <= '0;
      upd_target2_q      <= '0;
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      upd_branch1_q      <= upd_branch1_d;
      upd_taken1_q       <= upd_taken1_d;
      upd_pc1_q          <= upd_pc1_d;
      upd_target1_q      <= upd_target1_d;
      upd_branch2_q      <= upd_branch2_d;
      upd_taken2_q       <= upd_taken2_d;
      upd_pc2_q          <= upd_pc2_d;
      upd_target2_q      <= upd_target2_d;
      flush_q            <= flush_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.upd_branch1      = upd_branch1_q;
  assign bus.upd_taken1       = upd_taken1_q;
  assign bus.upd_pc1          = upd_pc1_q;
  assign bus.upd_target1      = upd_target1_q;
  assign bus.upd_branch2      = upd_branch2_q;
  assign bus.upd_taken2       = upd_taken2_q;
  assign bus.upd_pc2          = upd_pc2_q;
  assign bus.upd_target2      = upd_target2_q;
  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit against an in-flight
// instruction queue model.
module tb_branch_resolve_unit;

  localparam int PC_W  = 9;
  localparam int DEPTH = 3;
  localparam int CNT_W = 16;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bru_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit       v;
    bit [8:0] pc;
    bit       pred;
    bit [8:0] pt;
  } ent_t;

  // Index 0 = youngest, index DEPTH-1 = instruction at Memory.
  ent_t q1[$];
  ent_t q2[$];

  bit       e_ub1, e_tk1, e_ub2, e_tk2, e_flush;
  bit [8:0] e_pc1, e_tg1, e_pc2, e_tg2, e_redir;
  int       e_bc, e_mc;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q1.delete();
    q2.delete();
    for (int i = 0; i < DEPTH; i++) begin
      q1.push_back('{0, 0, 0, 0});
      q2.push_back('{0, 0, 0, 0});
    end
    {e_ub1, e_tk1, e_ub2, e_tk2, e_flush} = '0;
    {e_pc1, e_tg1, e_pc2, e_tg2, e_redir} = '0;
    e_bc = 0;
    e_mc = 0;
  endtask

  function automatic bit wrong(ent_t e, bit tk, bit [8:0] tgt);
    return (e.pred != tk) || (tk && e.pt != tgt);
  endfunction

  // Predicts what the DUT registers on the coming edge from the current inputs.
  task automatic model_edge();
    ent_t m1, m2;
    bit r1, r2, mp1, mp2;
    bit [8:0] c1, c2;
    if (!reset) begin
      model_clear();
      return;
    end
    {e_ub1, e_tk1, e_ub2, e_tk2, e_flush} = '0;
    {e_pc1, e_tg1, e_pc2, e_tg2} = '0;
    if (bus.stall) return;
    m1  = q1[DEPTH-1];
    m2  = q2[DEPTH-1];
    r1  = m1.v && bus.m_branch1;
    mp1 = r1 && wrong(m1, bus.m_taken1, bus.m_target1);
    r2  = m2.v && bus.m_branch2 && !mp1;
    mp2 = r2 && wrong(m2, bus.m_taken2, bus.m_target2);
    c1  = bus.m_taken1 ? bus.m_target1 : 9'((int'(m1.pc) + 1) % 512);
    c2  = bus.m_taken2 ? bus.m_target2 : 9'((int'(m2.pc) + 1) % 512);
    if (r1) begin e_ub1 = 1; e_tk1 = bus.m_taken1; e_pc1 = m1.pc; e_tg1 = bus.m_target1; end
    if (r2) begin e_ub2 = 1; e_tk2 = bus.m_taken2; e_pc2 = m2.pc; e_tg2 = bus.m_target2; end
    e_flush = mp1 || mp2;
    if (mp1) e_redir = c1;
    else if (mp2) e_redir = c2;
    e_bc = e_bc + int'(r1) + int'(r2);
    if (e_bc > CMAX) e_bc = CMAX;
    if (e_flush && e_mc < CMAX) e_mc++;
    void'(q1.pop_back());
    void'(q2.pop_back());
    q1.push_front('{bus.fetch_valid1, bus.fetch_pc1, bus.fetch_pred1, bus.fetch_ptarget1});
    q2.push_front('{bus.fetch_valid2, bus.fetch_pc2, bus.fetch_pred2, bus.fetch_ptarget2});
    if (e_flush) begin
      foreach (q1[i]) q1[i].v = 0;
      foreach (q2[i]) q2[i].v = 0;
    end
  endtask

  task automatic check_all();
    chk("upd_branch1", 32'(bus.upd_branch1), 32'(e_ub1));
    chk("upd_taken1", 32'(bus.upd_taken1), 32'(e_tk1));
    chk("upd_pc1", 32'(bus.upd_pc1), 32'(e_pc1));
    chk("upd_target1", 32'(bus.upd_target1), 32'(e_tg1));
    chk("upd_branch2", 32'(bus.upd_branch2), 32'(e_ub2));
    chk("upd_taken2", 32'(bus.upd_taken2), 32'(e_tk2));
    chk("upd_pc2", 32'(bus.upd_pc2), 32'(e_pc2));
    chk("upd_target2", 32'(bus.upd_target2), 32'(e_tg2));
    chk("flush", 32'(bus.flush), 32'(e_flush));
    chk("redirect_pc", 32'(bus.redirect_pc), 32'(e_redir));
    chk("branch_count", 32'(bus.branch_count), 32'(e_bc));
    chk("mispredict_count", 32'(bus.mispredict_count), 32'(e_mc));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    bus.stall = 0;
    bus.fetch_valid1 = 0; bus.fetch_pc1 = 0; bus.fetch_pred1 = 0; bus.fetch_ptarget1 = 0;
    bus.fetch_valid2 = 0; bus.fetch_pc2 = 0; bus.fetch_pred2 = 0; bus.fetch_ptarget2 = 0;
    bus.m_branch1 = 0; bus.m_taken1 = 0; bus.m_target1 = 0;
    bus.m_branch2 = 0; bus.m_taken2 = 0; bus.m_target2 = 0;
  endtask

  // Single slot1 instruction: fetch, travel DEPTH stages, resolve with given outcome.
  task automatic run_insn(bit [8:0] pc, bit pred, bit [8:0] pt, bit tk, bit [8:0] tgt);
    bus.fetch_valid1 = 1; bus.fetch_pc1 = pc; bus.fetch_pred1 = pred; bus.fetch_ptarget1 = pt;
    step();
    bus.fetch_valid1 = 0;
    repeat (DEPTH - 1) step();
    bus.m_branch1 = 1; bus.m_taken1 = tk; bus.m_target1 = tgt;
    step();
    bus.m_branch1 = 0; bus.m_taken1 = 0; bus.m_target1 = 0;
  endtask

  task automatic rand_inputs();
    bus.stall          = ($urandom_range(0, 4) == 0);
    bus.fetch_valid1   = $urandom_range(0, 3) != 0;
    bus.fetch_valid2   = $urandom_range(0, 3) != 0;
    bus.fetch_pc1      = 9'($urandom);
    bus.fetch_pc2      = 9'($urandom);
    bus.fetch_pred1    = 1'($urandom);
    bus.fetch_pred2    = 1'($urandom);
    bus.fetch_ptarget1 = 9'($urandom);
    bus.fetch_ptarget2 = 9'($urandom);
    bus.m_branch1      = 1'($urandom);
    bus.m_branch2      = 1'($urandom);
    bus.m_taken1       = 1'($urandom);
    bus.m_taken2       = 1'($urandom);
    bus.m_target1      = ($urandom_range(0, 1) != 0) ? q1[DEPTH-1].pt : 9'($urandom);
    bus.m_target2      = ($urandom_range(0, 1) != 0) ? q2[DEPTH-1].pt : 9'($urandom);
  endtask

  initial begin
    model_clear();
    // Reset with garbage on every input.
    reset = 0;
    rand_inputs();
    bus.m_branch1 = 1; bus.m_branch2 = 1;
    repeat (3) step();
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_upd_branch1", 32'(bus.upd_branch1), 32'h0);
    chk("rst_branch_count", 32'(bus.branch_count), 32'h0);
    reset = 1;
    set_idle();
    step();

    run_insn(9'h010, 0, 9'h000, 0, 9'h000);
    chk("t1_upd_branch1", 32'(bus.upd_branch1), 32'h1);
    chk("t1_upd_taken1", 32'(bus.upd_taken1), 32'h0);
    chk("t1_upd_pc1", 32'(bus.upd_pc1), 32'h010);
    chk("t1_flush", 32'(bus.flush), 32'h0);
    chk("t1_branch_count", 32'(bus.branch_count), 32'd1);

    run_insn(9'h020, 0, 9'h000, 1, 9'h040);
    chk("t2_flush", 32'(bus.flush), 32'h1);
    chk("t2_redirect", 32'(bus.redirect_pc), 32'h040);
    chk("t2_mispredict_count", 32'(bus.mispredict_count), 32'd1);
    chk("t2_upd_target1", 32'(bus.upd_target1), 32'h040);
    step();
    chk("t2_flush_one_cycle", 32'(bus.flush), 32'h0);
    chk("t2_redirect_hold", 32'(bus.redirect_pc), 32'h040);

    run_insn(9'h030, 1, 9'h050, 1, 9'h060);
    chk("t3_flush", 32'(bus.flush), 32'h1);
    chk("t3_redirect", 32'(bus.redirect_pc), 32'h060);

    run_insn(9'h1FF, 0, 9'h000, 0, 9'h000);
    chk("t4_no_flush", 32'(bus.flush), 32'h0);

    run_insn(9'h1FF, 1, 9'h0AB, 0, 9'h123);
    chk("t5_flush", 32'(bus.flush), 32'h1);
    chk("t5_redirect_wrap", 32'(bus.redirect_pc), 32'h000);
    chk("t5_counts", 32'({bus.branch_count, bus.mispredict_count}), {16'd5, 16'd3});

    // Both slots mispredict: only slot1 counts; younger work is squashed.
    bus.fetch_valid1 = 1; bus.fetch_pc1 = 9'h100; bus.fetch_pred1 = 0; bus.fetch_ptarget1 = 0;
    bus.fetch_valid2 = 1; bus.fetch_pc2 = 9'h101; bus.fetch_pred2 = 0; bus.fetch_ptarget2 = 0;
    step();
    for (int i = 0; i < DEPTH - 1; i++) begin
      bus.fetch_pc1 = 9'(9'h110 + i); bus.fetch_pc2 = 9'(9'h120 + i);
      step();
    end
    bus.m_branch1 = 1; bus.m_taken1 = 1; bus.m_target1 = 9'h080;
    bus.m_branch2 = 1; bus.m_taken2 = 1; bus.m_target2 = 9'h0AA;
    step();
    chk("t6_upd_branch1", 32'(bus.upd_branch1), 32'h1);
    chk("t6_upd_branch2", 32'(bus.upd_branch2), 32'h0);
    chk("t6_redirect", 32'(bus.redirect_pc), 32'h080);
    chk("t6_counts", 32'({bus.branch_count, bus.mispredict_count}), {16'd6, 16'd4});
    bus.fetch_valid1 = 0; bus.fetch_valid2 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t6_squashed", 32'({bus.upd_branch1, bus.upd_branch2, bus.flush}), 32'h0);
    end
    set_idle();

    // Stall with a branch waiting at Memory; order A then B preserved.
    bus.fetch_valid1 = 1; bus.fetch_pc1 = 9'h0A0;
    step();
    bus.fetch_pc1 = 9'h0A1;
    step();
    bus.fetch_valid1 = 0;
    repeat (DEPTH - 2) step();
    bus.stall = 1; bus.m_branch1 = 1;
    repeat (4) begin
      step();
      chk("t7_stall_no_upd", 32'(bus.upd_branch1), 32'h0);
    end
    bus.stall = 0;
    step();
    chk("t7_upd_a", 32'({bus.upd_branch1, bus.upd_pc1}), {22'h0, 1'b1, 9'h0A0});
    step();
    chk("t7_upd_b", 32'({bus.upd_branch1, bus.upd_pc1}), {22'h0, 1'b1, 9'h0A1});
    bus.m_branch1 = 0;
    step();
    chk("t7_done", 32'(bus.upd_branch1), 32'h0);
    chk("t7_branch_count", 32'(bus.branch_count), 32'd8);

    repeat (600) begin
      rand_inputs();
      step();
    end
    set_idle();
    step();

    // Correct two-wide stream until branch_count saturates.
    bus.fetch_valid1 = 1; bus.fetch_valid2 = 1;
    bus.m_branch1 = 1; bus.m_branch2 = 1;
    repeat (33000) begin
      bus.fetch_pc1 = 9'($urandom); bus.fetch_pc2 = 9'($urandom);
      step();
    end
    chk("sat_branch_count", 32'(bus.branch_count), 32'h0000FFFF);
    step();
    chk("sat_branch_hold", 32'(bus.branch_count), 32'h0000FFFF);

    // Reset mid-stream with a mispredict pending at Memory.
    bus.m_taken1 = 1; bus.m_target1 = 9'h0EE;
    reset = 0;
    step();
    chk("mrst_flush", 32'(bus.flush), 32'h0);
    chk("mrst_counts", 32'({bus.branch_count, bus.mispredict_count}), 32'h0);
    reset = 1;
    bus.fetch_valid1 = 0; bus.fetch_valid2 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("mrst_no_stale", 32'({bus.upd_branch1, bus.upd_branch2, bus.flush}), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
